// File: rtl/dram_pkg.sv
// Shared types and command decode for the multi-bank behavioural DRAM model.
package dram_pkg;

  // Commands recognised on one rising edge of CK.
  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE} cmd_e;

  // Per-bank row state.
  typedef enum logic [1:0] {IDLE, OPENING, ACTIVE} bank_state_e;

  // Width of the read burst beat counter; wide enough for the longest burst (8).
  localparam int BURST_W = 4;

  // Map the strobes onto a command. wen_all is the AND of every byte write
  // enable: all-high means READ, any lane low means WRITE.
  function automatic cmd_e cmd_decode(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic wen_all);
    cmd_e c;
    c = NOP;
    if (!cs_n) begin
      case ({ras_n, cas_n})
        2'b01:   c = ACT;
        2'b10:   c = wen_all ? RD : WR;
        2'b00:   c = PRE;
        default: c = NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/dram_bank_fsm.sv
// One DRAM bank: open-row register, TRCD wait and IDLE/OPENING/ACTIVE state.
// The top level only presents act when the bank is IDLE; pre is always legal.
module dram_bank_fsm
  import dram_pkg::*;
#(
  parameter int ROW_W = 11,
  parameter int TRCD  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             pre,
  input  logic [ROW_W-1:0] row,
  output bank_state_e      state,
  output logic             bank_active,
  output logic [ROW_W-1:0] open_row
);

  localparam int CNT_W = (TRCD > 2) ? $clog2(TRCD) : 1;
  // Loaded on ACTIVATE; the bank turns ACTIVE on the edge where the count is 1,
  // so a column command TRCD edges after ACTIVATE sees ACTIVE.
  localparam logic [CNT_W-1:0] TRCD_M1 = CNT_W'((TRCD > 1) ? TRCD - 1 : 0);

  bank_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;

  // State, TRCD counter and open row registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  // Next-state logic: ACT opens, the counter times TRCD, PRE closes from any state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (act) begin
          row_d = row;
          if (TRCD > 1) begin
            state_d = OPENING;
            cnt_d   = TRCD_M1;
          end else begin
            state_d = ACTIVE;
          end
        end
      end
      OPENING: begin
        if (pre) state_d = IDLE;
        else if (cnt_q <= CNT_W'(1)) state_d = ACTIVE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      ACTIVE: begin
        if (pre) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state       = state_q;
  assign bank_active = (state_q == ACTIVE);
  assign open_row    = row_q;

endmodule

// File: rtl/dram_bank_model.sv
// Multi-bank behavioural DRAM: per-bank open rows, TRCD check, CL-deep read
// pipeline, BL-beat read bursts, byte-masked writes and a sticky ERR flag.
// Read data interface: VALID is a strobe with no backpressure. Q carries a
// beat exactly on the cycles VALID is 1 and holds the last beat otherwise;
// the host must capture Q on every cycle VALID is high.
// Storage keeps only the low MEM_ROW_W row bits, so rows alias modulo
// 2^MEM_ROW_W; the image used in simulation must fit inside that window.
module dram_bank_model
  import dram_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int BANKS     = 4,
  parameter int ROW_W     = 11,
  parameter int COL_W     = 10,
  parameter int CL        = 5,
  parameter int TRCD      = 3,
  parameter int BL        = 1,
  parameter int MEM_ROW_W = 4,
  localparam int BA_W     = $clog2(BANKS)
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                CSn,
  input  logic                RASn,
  input  logic                CASn,
  input  logic [DATA_W/8-1:0] WEn,
  input  logic [BA_W-1:0]     BA,
  input  logic [ROW_W-1:0]    A,
  input  logic [DATA_W-1:0]   D,
  output logic [DATA_W-1:0]   Q,
  output logic                VALID,
  output logic                ERR
);

  localparam int LANES  = DATA_W / 8;
  localparam int MEM_AW = BA_W + MEM_ROW_W + COL_W;
  localparam logic [BURST_W-1:0] BL_M1 = BURST_W'(BL - 1);

  cmd_e                 cmd;
  bank_state_e          bank_state [BANKS];
  logic [BANKS-1:0]     bank_active;
  logic [ROW_W-1:0]     open_row [BANKS];
  logic [BANKS-1:0]     act_vec, pre_vec;
  logic                 busy, act_err, col_err, rd_go, wr_go;
  logic [MEM_AW-1:0]    col_addr;
  logic                 unused_row_hi;

  logic [DATA_W-1:0]    mem [2**MEM_AW];

  logic [CL-1:0]        pipe_vld;
  logic [MEM_AW-1:0]    pipe_addr [CL];

  logic [BURST_W-1:0]   burst_left;
  logic [MEM_AW-COL_W-1:0] burst_base;
  logic [COL_W-1:0]     burst_col;

  assign cmd = cmd_decode(CSn, RASn, CASn, &WEn);

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    dram_bank_fsm #(
      .ROW_W (ROW_W),
      .TRCD  (TRCD)
    ) u_fsm (
      .clk         (CK),
      .rst         (RST),
      .act         (act_vec[b]),
      .pre         (pre_vec[b]),
      .row         (A),
      .state       (bank_state[b]),
      .bank_active (bank_active[b]),
      .open_row    (open_row[b])
    );
  end

  // Legality checks and per-bank command steering; illegal commands are dropped.
  always_comb begin
    busy     = (|pipe_vld) || (burst_left != '0);
    act_err  = (cmd == ACT) && (bank_state[BA] != IDLE);
    col_err  = ((cmd == RD) || (cmd == WR)) && (!bank_active[BA] || busy);
    rd_go    = (cmd == RD) && !col_err;
    wr_go    = (cmd == WR) && !col_err;
    col_addr = {BA, open_row[BA][MEM_ROW_W-1:0], A[COL_W-1:0]};
    act_vec  = '0;
    pre_vec  = '0;
    for (int b = 0; b < BANKS; b++) begin
      act_vec[b] = (cmd == ACT) && !act_err && (BA == BA_W'(b));
      pre_vec[b] = (cmd == PRE) && (BA == BA_W'(b));
    end
  end

  // Row bits above the stored window are deliberately dropped from addressing.
  always_comb begin
    unused_row_hi = 1'b0;
    for (int b = 0; b < BANKS; b++) unused_row_hi = unused_row_hi ^ (^(open_row[b] >> MEM_ROW_W));
  end

  // Read latency pipeline: the issued word address walks CL stages.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      pipe_vld <= '0;
      for (int i = 0; i < CL; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld[0]  <= rd_go;
      pipe_addr[0] <= col_addr;
      for (int i = 1; i < CL; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Beat generator: first beat from the pipeline head, then BL-1 more beats
  // with the column wrapping inside the row. Memory is sampled at beat time.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      Q          <= '0;
      VALID      <= 1'b0;
      burst_left <= '0;
      burst_base <= '0;
      burst_col  <= '0;
    end else if (pipe_vld[CL-1]) begin
      Q          <= mem[pipe_addr[CL-1]];
      VALID      <= 1'b1;
      burst_left <= BL_M1;
      burst_base <= pipe_addr[CL-1][MEM_AW-1:COL_W];
      burst_col  <= pipe_addr[CL-1][COL_W-1:0] + COL_W'(1);
    end else if (burst_left != '0) begin
      Q          <= mem[{burst_base, burst_col}];
      VALID      <= 1'b1;
      burst_left <= burst_left - BURST_W'(1);
      burst_col  <= burst_col + COL_W'(1);
    end else begin
      VALID      <= 1'b0;
    end
  end

  // Byte-lane writes; storage is not reset so the image survives RST.
  always_ff @(posedge CK) begin
    if (wr_go) begin
      for (int i = 0; i < LANES; i++) begin
        if (!WEn[i]) mem[col_addr][8*i +: 8] <= D[8*i +: 8];
      end
    end
  end

  // Sticky protocol error flag, cleared only by reset.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) ERR <= 1'b0;
    else if (act_err || col_err) ERR <= 1'b1;
  end

endmodule
